sram_burst_reader: RTL

- Read-side master for the team's parameterized synchronous memory, which has a registered read: data appears one clock after the address is presented.
- Accepts a burst request (start address, word count) over a valid/ready handshake.
- Drives the memory read address and absorbs the 1-cycle read latency in a 2-entry skid buffer.
- Streams the words out with valid/ready backpressure and a last flag.

---
 rtl/sram_rd_pkg.sv | 33 +++
 rtl/sram_rd_skid_buf.sv | 109 ++++++++++
 rtl/sram_burst_reader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sram_rd_pkg.sv
// -----------------------------------------------------------------------------
// sram_rd_pkg
// Shared types and constants for the SRAM burst reader.
//   rd_state_t       : burst FSM states (IDLE, ISSUE, DRAIN)
//   SKID_DEPTH       : entries in the read-latency skid buffer
//   SKID_CNT_W       : width of the skid buffer occupancy count
//   skid_has_room()  : issue-permission rule for the skid buffer
// -----------------------------------------------------------------------------
package sram_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   localparam int SKID_DEPTH = 2;
   localparam int SKID_CNT_W = 2;

   // A new read may be issued only if every word already committed (buffered
   // or in flight), minus the word leaving this cycle, still leaves a free slot
   // for it when it lands.
   function automatic logic skid_has_room(input logic [SKID_CNT_W-1:0] count,
                                          input logic                  inflight,
                                          input logic                  pop);
      logic [SKID_CNT_W:0] occ;
      occ = {1'b0, count}
          + {{SKID_CNT_W{1'b0}}, inflight}
          - {{SKID_CNT_W{1'b0}}, pop};
      return (occ < (SKID_CNT_W+1)'(SKID_DEPTH));
   endfunction

endpackage

// File: rtl/sram_rd_skid_buf.sv
// -----------------------------------------------------------------------------
// sram_rd_skid_buf
// Two-entry shift FIFO holding {last, data}. Entry 0 is always the head, so
// the head outputs come straight from registers. Empty entries are kept at
// zero, so head_data/head_last read 0 whenever the buffer is empty.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   push, push_data,
//   push_last           : write a word (ignored if full and not popping)
//   pop                 : remove the head word (caller qualifies with valid)
//   count               : occupancy 0..2
//   valid               : head entry holds a word
//   head_data, head_last: head entry contents
// -----------------------------------------------------------------------------
module sram_rd_skid_buf
   import sram_rd_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_data,
   input  logic                  push_last,
   input  logic                  pop,
   output logic [SKID_CNT_W-1:0] count,
   output logic                  valid,
   output logic [WIDTH-1:0]      head_data,
   output logic                  head_last
);

   localparam int EW = WIDTH + 1;

   logic [EW-1:0]         ent0_r;
   logic [EW-1:0]         ent1_r;
   logic [EW-1:0]         ent0_n_s;
   logic [EW-1:0]         ent1_n_s;
   logic [EW-1:0]         push_ent_s;
   logic [SKID_CNT_W-1:0] cnt_r;
   logic [SKID_CNT_W-1:0] cnt_n_s;
   logic                  valid_r;

   assign push_ent_s = {push_last, push_data};

   // Next-state of the two entries and the occupancy count.
   always_comb begin
      ent0_n_s = ent0_r;
      ent1_n_s = ent1_r;
      cnt_n_s  = cnt_r;
      case ({push, pop})
         2'b10: begin
            if (cnt_r == 2'd0) begin
               ent0_n_s = push_ent_s;
               cnt_n_s  = 2'd1;
            end else if (cnt_r == 2'd1) begin
               ent1_n_s = push_ent_s;
               cnt_n_s  = 2'd2;
            end else begin
               cnt_n_s  = cnt_r;
            end
         end
         2'b01: begin
            if (cnt_r != 2'd0) begin
               ent0_n_s = ent1_r;
               ent1_n_s = {EW{1'b0}};
               cnt_n_s  = cnt_r - 2'd1;
            end else begin
               cnt_n_s  = cnt_r;
            end
         end
         2'b11: begin
            // Push and pop together: occupancy unchanged, order preserved.
            if (cnt_r == 2'd2) begin
               ent0_n_s = ent1_r;
               ent1_n_s = push_ent_s;
            end else if (cnt_r == 2'd1) begin
               ent0_n_s = push_ent_s;
            end else begin
               ent0_n_s = push_ent_s;
               cnt_n_s  = 2'd1;
            end
         end
         default: begin
            cnt_n_s = cnt_r;
         end
      endcase
   end

   // Entry, count and valid registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent0_r  <= {EW{1'b0}};
         ent1_r  <= {EW{1'b0}};
         cnt_r   <= 2'd0;
         valid_r <= 1'b0;
      end else begin
         ent0_r  <= ent0_n_s;
         ent1_r  <= ent1_n_s;
         cnt_r   <= cnt_n_s;
         valid_r <= (cnt_n_s != 2'd0);
      end
   end

   assign count     = cnt_r;
   assign valid     = valid_r;
   assign head_data = ent0_r[WIDTH-1:0];
   assign head_last = ent0_r[WIDTH];

endmodule

// File: rtl/sram_burst_reader.sv
// -----------------------------------------------------------------------------
// sram_burst_reader
// Read-side burst master for a synchronous memory with a one-cycle registered
// read. A request (start address, length) is accepted over valid/ready; the
// block then issues one address per cycle (wrapping modulo DEPTH), absorbs the
// read latency in a two-entry skid buffer and streams the words out with
// valid/ready backpressure and a last flag.
//
// Optional feature (macro SRAM_RD_WRAP_ERR_EN): requests that would wrap past
// the end of memory (req_addr + req_len > DEPTH) are completed on the
// handshake but rejected, with a one-cycle err pulse. Without the macro err
// is constant 0 and bursts wrap.
//
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid/req_ready           : burst request handshake
//   req_addr, req_len             : burst start address and word count
//   mem_read_addr, mem_read_data  : memory read port (data one clock later)
//   out_valid/out_ready           : output word handshake
//   out_data, out_last            : output word and end-of-burst flag
//   busy                          : from accept until the last word is popped
//   err                           : rejected-request pulse
// -----------------------------------------------------------------------------
module sram_burst_reader
   import sram_rd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int ADDR  = 2,
   parameter int LEN_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [ADDR-1:0]  req_addr,
   input  logic [LEN_W-1:0] req_len,
   output logic [ADDR-1:0]  mem_read_addr,
   input  logic [WIDTH-1:0] mem_read_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic             err
);

   rd_state_t             state_r;
   logic                  req_ready_r;
   logic [ADDR-1:0]       next_addr_r;
   logic [ADDR-1:0]       hold_addr_r;
   logic [LEN_W-1:0]      len_r;
   logic [LEN_W-1:0]      issue_cnt_r;
   logic                  inflight_r;
   logic                  inflight_last_r;
   logic                  busy_r;
   logic                  err_r;

   logic                  accept_s;
   logic                  reject_s;
   logic                  pop_s;
   logic                  issue_s;
   logic                  final_s;
   logic [LEN_W-1:0]      cnt_inc_s;
   logic [SKID_CNT_W-1:0] buf_count_s;

   assign accept_s  = req_valid && req_ready_r;
   assign pop_s     = out_valid && out_ready;
   assign cnt_inc_s = issue_cnt_r + LEN_W'(1'b1);
   assign final_s   = (cnt_inc_s == len_r);

`ifdef SRAM_RD_WRAP_ERR_EN
   logic [LEN_W:0] span_s;
   assign span_s   = (LEN_W+1)'(req_addr) + (LEN_W+1)'(req_len);
   assign reject_s = (req_len > LEN_W'(DEPTH)) || (span_s > (LEN_W+1)'(DEPTH));
`else
   assign reject_s = 1'b0;
`endif

   // Issue decision and memory address. The address is driven in the issue
   // cycle itself so the registered memory read lands exactly one cycle later,
   // which is what lets a single in-flight flag account for the read latency.
   always_comb begin
      issue_s       = 1'b0;
      mem_read_addr = hold_addr_r;
      if ((state_r == ISSUE) && skid_has_room(buf_count_s, inflight_r, pop_s)) begin
         issue_s       = 1'b1;
         mem_read_addr = next_addr_r;
      end else begin
         issue_s       = 1'b0;
         mem_read_addr = hold_addr_r;
      end
   end

   // Burst FSM with its registered handshake, busy and error outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         req_ready_r <= 1'b1;
         next_addr_r <= {ADDR{1'b0}};
         hold_addr_r <= {ADDR{1'b0}};
         len_r       <= {LEN_W{1'b0}};
         issue_cnt_r <= {LEN_W{1'b0}};
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s && reject_s) begin
                  err_r <= 1'b1;
               end else if (accept_s && (req_len != {LEN_W{1'b0}})) begin
                  state_r     <= ISSUE;
                  req_ready_r <= 1'b0;
                  next_addr_r <= req_addr;
                  len_r       <= req_len;
                  issue_cnt_r <= {LEN_W{1'b0}};
                  busy_r      <= 1'b1;
               end else begin
                  // Zero-length request or nothing offered: stay idle.
                  state_r     <= IDLE;
               end
            end
            ISSUE: begin
               if (issue_s) begin
                  hold_addr_r <= next_addr_r;
                  next_addr_r <= next_addr_r + ADDR'(1'b1);
                  issue_cnt_r <= cnt_inc_s;
                  if (final_s) begin
                     state_r <= DRAIN;
                  end else begin
                     state_r <= ISSUE;
                  end
               end else begin
                  state_r <= ISSUE;
               end
            end
            DRAIN: begin
               if (pop_s && out_last) begin
                  busy_r <= 1'b0;
               end else begin
                  busy_r <= busy_r;
               end
               if (!inflight_r && (buf_count_s == 2'd0)) begin
                  state_r     <= IDLE;
                  req_ready_r <= 1'b1;
               end else begin
                  state_r     <= DRAIN;
               end
            end
            default: begin
               state_r     <= IDLE;
               req_ready_r <= 1'b1;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // In-flight tracking: a word issued this cycle arrives on the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
      end else begin
         inflight_r      <= issue_s;
         inflight_last_r <= issue_s && final_s;
      end
   end

   sram_rd_skid_buf #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_r),
      .push_data (mem_read_data),
      .push_last (inflight_last_r),
      .pop       (pop_s),
      .count     (buf_count_s),
      .valid     (out_valid),
      .head_data (out_data),
      .head_last (out_last)
   );

   assign req_ready = req_ready_r;
   assign busy      = busy_r;
   assign err       = err_r;

endmodule
